mux_rr_scheduler: RTL and testbench

- Round-robin scheduler that shares one 16:1 selection path between 2**N requesters and drives its select.
- Each requester presents a W-bit word and raises req.
- The block picks a winner, registers the select, and captures in_data[winner].
- It presents the captured word downstream under a valid/ready handshake, then acknowledges the winner.
- Sits between a bank of producers and a single serial consumer.

---
 rtl/mux_rr_pkg.sv | 24 ++
 rtl/rr_pick.sv | 42 ++++
 rtl/mux_rr_scheduler.sv | 124 ++++++++++++
 tb/tb_mux_rr_scheduler.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_rr_pkg.sv
// -----------------------------------------------------------------------------
// mux_rr_pkg
// Shared definitions for the round-robin mux scheduler:
//   - state_e     : scheduler state encoding (IDLE / GRANT)
//   - DEF_N/DEF_W : default select width and data word width
//   - wrap_start  : first index of a round-robin search, (last + 1) mod 2**n
// -----------------------------------------------------------------------------
package mux_rr_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam int DEF_N = 4;
    localparam int DEF_W = 8;

    // Start of the wrapped search: the slot just after the last winner.
    function automatic int unsigned wrap_start(input int unsigned last,
                                               input int unsigned n);
        return (last + 32'd1) % (32'd1 << n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Scans eligible from (last+1) upward,
// wrapping, and returns the first set bit.
// Ports:
//   eligible [2**N] : candidate requests
//   last     [N]    : index of the previous winner
//   found    [1]    : at least one eligible bit is set
//   winner   [N]    : index of the chosen requester (0 when found=0)
// -----------------------------------------------------------------------------
module rr_pick
    import mux_rr_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic [2**N-1:0] eligible,
    input  logic [N-1:0]    last,
    output logic            found,
    output logic [N-1:0]    winner
);

    logic [N-1:0] start;
    logic [N-1:0] idx;

    // NOTE: every signal written here gets a default before any conditional
    // assignment; a path that leaves one unassigned would infer a latch.
    always_comb begin
        start  = N'(wrap_start(32'(last), N));
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 0; i < 2**N; i++) begin
            // N-bit addition wraps modulo 2**N on its own.
            idx = start + N'(i);
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/mux_rr_scheduler.sv
// -----------------------------------------------------------------------------
// mux_rr_scheduler
// Round-robin scheduler sharing one selection path between 2**N requesters.
// Picks a winner, registers its select, captures its word and offers it
// downstream under valid/ready; the winner is acknowledged on the handshake.
// Optional feature macro: MUX_RR_SCHEDULER_LOCK_EN (adds 'lock' input; when
// set on a handshake with req[sel] still high, the same requester is
// re-granted for burst transfers without moving the rotation pointer).
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   req        : per-requester request level, held until ack
//   in_data    : flattened words, requester i at [i*W +: W]
//   out_ready  : consumer ready
//   out_valid  : out_data valid (registered, high in GRANT)
//   out_data   : captured word of the current winner
//   sel        : registered index of current/last winner
//   ack        : one-hot pulse to the winner on the handshake cycle
//   busy       : high in GRANT
//   lock       : (MUX_RR_SCHEDULER_LOCK_EN only) hold grant for a burst
// -----------------------------------------------------------------------------
module mux_rr_scheduler
    import mux_rr_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2**N-1:0]     req,
    input  logic [(2**N)*W-1:0] in_data,
    input  logic                out_ready,
`ifdef MUX_RR_SCHEDULER_LOCK_EN
    input  logic                lock,
`endif
    output logic                out_valid,
    output logic [W-1:0]        out_data,
    output logic [N-1:0]        sel,
    output logic [2**N-1:0]     ack,
    output logic                busy
);

    state_e         state_q, state_d;
    logic [N-1:0]   sel_q,   sel_d;
    logic [N-1:0]   last_q,  last_d;
    logic [W-1:0]   data_q,  data_d;

    logic           handshake;
    logic           relock;
    logic           load;
    logic [2**N-1:0] eligible;
    logic           found;
    logic [N-1:0]   winner;

    rr_pick #(.N(N)) u_pick (
        .eligible (eligible),
        .last     (last_q),
        .found    (found),
        .winner   (winner)
    );

    always_comb begin
        handshake = (state_q == GRANT) && out_ready;

`ifdef MUX_RR_SCHEDULER_LOCK_EN
        relock = handshake && lock && req[sel_q];
`else
        relock = 1'b0;
`endif

        // Mask the word being acknowledged this cycle so it is not re-granted.
        eligible = req;
        if (handshake) begin
            eligible[sel_q] = 1'b0;
        end

        // A new winner loads from IDLE or on a handshake (back-to-back).
        load = found && !relock && ((state_q == IDLE) || handshake);

        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        data_d  = data_q;

        if (load) begin
            state_d = GRANT;
            sel_d   = winner;
            last_d  = winner;
            data_d  = in_data[winner*W +: W];
        end else if (relock) begin
            // Burst continuation: same requester, rotation pointer untouched.
            data_d  = in_data[sel_q*W +: W];
        end else if (handshake) begin
            state_d = IDLE;
        end

        ack = '0;
        if (handshake) begin
            ack[sel_q] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            last_q  <= '1;  // first search then starts at index 0
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = (state_q == GRANT);
    assign busy      = (state_q == GRANT);
    assign out_data  = data_q;
    assign sel       = sel_q;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_scheduler
// Directed self-checking bench for mux_rr_scheduler (default build, N=4, W=8).
// Inputs change 3 time units after a rising edge; outputs are compared in the
// same window, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_mux_rr_scheduler;

    localparam int N = 4;
    localparam int W = 8;
    localparam int M = 2**N;

    logic             clk;
    logic             rst_n;
    logic [M-1:0]     req;
    logic [M*W-1:0]   in_data;
    logic             out_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [N-1:0]     sel;
    logic [M-1:0]     ack;
    logic             busy;

    int n_cmp;
    int n_err;

    mux_rr_scheduler #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .in_data   (in_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .sel       (sel),
        .ack       (ack),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic check_grant(input string tag, input logic [N-1:0] exp_sel,
                               input logic [W-1:0] exp_data,
                               input logic [M-1:0] exp_ack);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".busy"},  32'(busy),      32'd1);
        check({tag, ".sel"},   32'(sel),       32'(exp_sel));
        check({tag, ".data"},  32'(out_data),  32'(exp_data));
        check({tag, ".ack"},   32'(ack),       32'(exp_ack));
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".valid"}, 32'(out_valid), 32'd0);
        check({tag, ".busy"},  32'(busy),      32'd0);
        check({tag, ".ack"},   32'(ack),       32'd0);
    endtask

    task automatic set_word(input int i, input logic [W-1:0] v);
        in_data[i*W +: W] = v;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b1;
        req       = '0;
        in_data   = '0;
        out_ready = 1'b1;

        // ---------------- reset / idle ----------------
        #1;
        req   = 16'hA5C3;
        rst_n = 1'b0;
        tick();
        tick();
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.data",  32'(out_data),  32'd0);
        check("rst.sel",   32'(sel),       32'd0);
        check("rst.ack",   32'(ack),       32'd0);
        check("rst.busy",  32'(busy),      32'd0);
        req   = '0;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_idle("idle");
        end

        // ---------------- single request ----------------
        set_word(5, 8'hA5);
        req = 16'h0020;
        #1;
        check("single.pre_valid", 32'(out_valid), 32'd0);
        tick();
        check_grant("single.g1", 4'd5, 8'hA5, 16'h0020);
        // Held request is masked on its own handshake: one IDLE cycle.
        tick();
        check_idle("single.gap");
        tick();
        check_grant("single.g2", 4'd5, 8'hA5, 16'h0020);
        req = '0;
        tick();
        check_idle("single.end");

        // ---------------- rotation ----------------
        do_reset();
        for (int i = 0; i < M; i++) set_word(i, 8'(i));
        req = 16'hFFFF;
        for (int j = 0; j <= M; j++) begin
            tick();
            check_grant("rot", 4'(j % M), 8'(j % M), 16'(1 << (j % M)));
        end
        req = '0;
        tick();
        check_idle("rot.end");

        // ---------------- backpressure ----------------
        do_reset();
        set_word(0,  8'h11);
        set_word(15, 8'hFF);
        out_ready = 1'b0;
        req       = 16'h8001;
        tick();
        check_grant("bp.g0", 4'd0, 8'h11, 16'h0000);
        set_word(0, 8'h22);  // must not disturb the held word
        for (int i = 0; i < 4; i++) begin
            tick();
            check_grant("bp.hold", 4'd0, 8'h11, 16'h0000);
        end
        out_ready = 1'b1;
        #1;
        check("bp.ack0", 32'(ack), 32'h0001);
        tick();
        check_grant("bp.g15", 4'd15, 8'hFF, 16'h8000);
        tick();
        check_grant("bp.g0b", 4'd0, 8'h22, 16'h0001);
        req = '0;
        tick();
        check_idle("bp.end");

        // ---------------- wrap / fairness ----------------
        // last=0 now; a lone request on 14 sets last=14.
        set_word(14, 8'hEE);
        set_word(15, 8'hFF);
        set_word(0,  8'h11);
        req = 16'h4000;
        tick();
        check_grant("wrap.g14", 4'd14, 8'hEE, 16'h4000);
        req = 16'hC001;
        tick();
        check_grant("wrap.g15", 4'd15, 8'hFF, 16'h8000);
        tick();
        check_grant("wrap.g0",  4'd0,  8'h11, 16'h0001);
        tick();
        check_grant("wrap.g14b", 4'd14, 8'hEE, 16'h4000);
        req = '0;
        tick();
        check_idle("wrap.end");

        // ---------------- reset mid-operation ----------------
        set_word(1, 8'h5A);
        set_word(2, 8'h3C);
        out_ready = 1'b0;
        req       = 16'h0004;
        tick();
        check_grant("mid.g2", 4'd2, 8'h3C, 16'h0000);
        rst_n = 1'b0;
        #1;
        check("mid.valid", 32'(out_valid), 32'd0);
        check("mid.ack",   32'(ack),       32'd0);
        check("mid.sel",   32'(sel),       32'd0);
        check("mid.data",  32'(out_data),  32'd0);
        out_ready = 1'b1;
        tick();
        check_idle("mid.hold");
        req   = 16'h0006;
        rst_n = 1'b1;
        tick();
        check_grant("mid.after", 4'd1, 8'h5A, 16'h0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
